ex_md_stage: RTL and testbench
==============================

// Module: ex_md_stage
// PURPOSE
//  Parametrised EX stage of the 5-stage pipeline. Contains the W/M forwarding muxes, the ALU and the write-register select.
//  Adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers and a busy/stall handshake to hazard control.
//  Sits between the D/E and E/M pipeline registers.
// PARAMETERS
//  DATA_W  32  datapath width; also the MDU iteration count
//  REG_AW  5   register-index width
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         asynchronous reset, active-high
//  regData1D    in   DATA_W    rs operand from the D/E register
//  regData2D    in   DATA_W    rt operand from the D/E register
//  resultW      in   DATA_W    W-stage forward value
//  aluOutM      in   DATA_W    M-stage forward value
//  signExtImmE  in   DATA_W    immediate operand
//  rtE, rdE     in   REG_AW    destination candidates
//  forward1E    in   2         00 reg, 01 resultW, 10 aluOutM (11 = reg)
//  forward2E    in   2         same encoding, for the rt path
//  aluCtrlE     in   5         operation code, see BEHAVIOUR
//  aluSrcE      in   1         1: b = signExtImmE
//  regDstE      in   1         1: writeRegE = rdE, else rtE
//  flushE       in   1         E-stage instruction squashed this cycle
//  aluOutE      out  DATA_W    ALU / MFHI / MFLO result
//  writeDataE   out  DATA_W    forwarded rt value (store data)
//  writeRegE    out  REG_AW    destination register
//  mdBusyE      out  1         stall request; hazard unit freezes F/D/E while high
//  ovfE         out  1         signed overflow on ADD/SUB (see CONFIGURATION)
// BEHAVIOUR
//  Op codes: 00000 AND, 00001 OR, 00010 ADD, 00011 XOR, 01010 SUB, 01011 SLT, 01100 SLTU,
//    10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU, 10100 MFHI, 10101 MFLO, 10110 MTHI, 10111 MTLO.
//    Undefined codes give aluOutE = 0.
//  ALU path is combinational, zero latency.
//    - bit3 of the code inverts b and adds carry-in 1 (SUB/SLT/SLTU).
//    - SLT = sign of (a-b) corrected for overflow; SLTU = borrow out; result is zero-extended.
//  MTHI/MTLO write HI/LO with a at the clock edge, unless flushE or the MDU is busy.
//  MDU FSM: IDLE -> RUN -> DONE -> IDLE.
//    - IDLE: an MD op in E with !flushE latches |a|, |b| and the sign flags (signed ops), loads cnt = DATA_W-1, goes to RUN.
//    - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; cnt==0 -> DONE.
//    - DONE: HI/LO written (mul: HI = upper, LO = lower half; div: LO = quotient, HI = remainder).
//      Signs are fixed here: quotient negated if the operand signs differ; remainder takes the dividend's sign. Then go to IDLE.
//  mdBusyE = (MD op in E and state != DONE) or (MFHI/MFLO/MTHI/MTLO in E and state != IDLE).
//    - An MD op therefore stalls exactly DATA_W+1 cycles and leaves E in the DONE cycle.
//  MFHI/MFLO: aluOutE = HI/LO. A write completing in the same edge is not visible; the busy stall guarantees ordering.
//  Divide by zero: no trap. LO = all ones, HI = dividend. Takes the full DATA_W+1 cycles.
//  Signed DIV of most-negative by -1: LO = most-negative, HI = 0.
//  flushE while RUN: abort to IDLE next edge. HI/LO unchanged, mdBusyE drops the same cycle.
//  rst (any time, including mid-op): state IDLE, cnt 0, HI = LO = 0, internal operands 0.
//    Outputs are combinational: mdBusyE = 0 when E holds no MD op.
//  writeDataE is always the forwarded rt value, independent of aluSrcE.
// CONFIGURATION
//  EX_OVF_DETECT_EN defined:
//    - ovfE = signed overflow of ADD/SUB (operands of equal effective sign, result of differing sign).
//    - aluOutE still carries the wrapped sum; M stage squashes the write.
//  EX_OVF_DETECT_EN undefined: ovfE tied 0; ADD/SUB wrap silently.
// TESTING
//  1. ADD with forward1E=10, aluOutM=5, regData2D=7, aluSrcE=0 -> aluOutE=12, writeRegE=rtE when regDstE=0.
//  2. SLT a=0x80000000, b=1 -> aluOutE=1; SLTU with same operands -> aluOutE=0.
//  3. MULT a=-3, b=7 -> mdBusyE high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; MFLO next returns 0xFFFFFFEB.
//  4. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=9, b=0 -> LO=0xFFFFFFFF, HI=9.
//  5. MULTU started, flushE pulsed in RUN cycle 10 -> state IDLE next edge, HI/LO keep the prior values.
//     rst in RUN -> HI=LO=0.
//  6. ADD 0x7FFFFFFF+1 -> ovfE=1 with EX_OVF_DETECT_EN, ovfE=0 without; aluOutE=0x80000000 in both builds.

Source files
------------

// File: rtl/ex_md_stage_if.sv
// EX-stage bus bundle: operands, forwards and controls in; ALU result, store data, dest and stall out.
// Latency: n/a (signal bundle only).
// Backpressure: mdBusyE is the only back-channel; the hazard unit freezes F/D/E while it is high.
// Ports: master = pipeline/hazard side driving the E-stage, slave = ex_md_stage.
interface ex_md_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [DATA_W-1:0] regData1D;
  logic [DATA_W-1:0] regData2D;
  logic [DATA_W-1:0] resultW;
  logic [DATA_W-1:0] aluOutM;
  logic [DATA_W-1:0] signExtImmE;
  logic [REG_AW-1:0] rtE;
  logic [REG_AW-1:0] rdE;
  logic [1:0]        forward1E;
  logic [1:0]        forward2E;
  logic [4:0]        aluCtrlE;
  logic              aluSrcE;
  logic              regDstE;
  logic              flushE;
  logic [DATA_W-1:0] aluOutE;
  logic [DATA_W-1:0] writeDataE;
  logic [REG_AW-1:0] writeRegE;
  logic              mdBusyE;
  logic              ovfE;

  modport master (
    output regData1D, regData2D, resultW, aluOutM, signExtImmE, rtE, rdE,
           forward1E, forward2E, aluCtrlE, aluSrcE, regDstE, flushE,
    input  aluOutE, writeDataE, writeRegE, mdBusyE, ovfE
  );

  modport slave (
    input  regData1D, regData2D, resultW, aluOutM, signExtImmE, rtE, rdE,
           forward1E, forward2E, aluCtrlE, aluSrcE, regDstE, flushE,
    output aluOutE, writeDataE, writeRegE, mdBusyE, ovfE
  );
endinterface

// File: rtl/ex_md_stage.sv
// EX stage: W/M forwarding muxes, ALU, write-register select, iterative mul/div unit with HI/LO.
// Latency: ALU path combinational; MULT/MULTU/DIV/DIVU stall DATA_W+1 cycles, HI/LO valid after.
// Backpressure: mdBusyE stalls F/D/E while an MD op runs or a HI/LO access waits for the MDU.
// Ports: clk, rst (async, active-high), bus (ex_md_stage_if.slave).
// Optional build macro EX_OVF_DETECT_EN: drives ovfE with signed ADD/SUB overflow (else tied 0).
module ex_md_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst,
  ex_md_stage_if.slave bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b01010;
  localparam logic [4:0] OP_SLT  = 5'b01011;
  localparam logic [4:0] OP_SLTU = 5'b01100;
  localparam logic [4:0] OP_MFHI = 5'b10100;
  localparam logic [4:0] OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_MTHI = 5'b10110;
  localparam logic [4:0] OP_MTLO = 5'b10111;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi, lo;
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd;
  logic              is_div, sign_a, sign_b;

  logic [4:0]        op;
  logic [DATA_W-1:0] a, rt_fwd, b, b_eff;
  logic [DATA_W:0]   sum;
  logic              ovf_raw;
  logic              is_md_op, is_hilo_op;

  assign op = bus.aluCtrlE;

  // ---------------- forwarding and operand select ----------------
  always_comb begin
    case (bus.forward1E)
      2'b01:   a = bus.resultW;
      2'b10:   a = bus.aluOutM;
      default: a = bus.regData1D;
    endcase
    case (bus.forward2E)
      2'b01:   rt_fwd = bus.resultW;
      2'b10:   rt_fwd = bus.aluOutM;
      default: rt_fwd = bus.regData2D;
    endcase
  end

  assign b              = bus.aluSrcE ? bus.signExtImmE : rt_fwd;
  assign bus.writeDataE = rt_fwd;
  assign bus.writeRegE  = bus.regDstE ? bus.rdE : bus.rtE;

  // ---------------- ALU ----------------
  // Bit 3 of the op code turns the adder into a subtractor (SUB/SLT/SLTU).
  assign b_eff   = op[3] ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, op[3]};
  // Overflow: equal effective operand signs but the result sign differs.
  assign ovf_raw = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

  always_comb begin
    bus.aluOutE = '0;
    case (op)
      OP_AND:  bus.aluOutE = a & b;
      OP_OR:   bus.aluOutE = a | b;
      OP_XOR:  bus.aluOutE = a ^ b;
      OP_ADD,
      OP_SUB:  bus.aluOutE = sum[DATA_W-1:0];
      OP_SLT:  bus.aluOutE = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ ovf_raw};
      OP_SLTU: bus.aluOutE = {{(DATA_W-1){1'b0}}, ~sum[DATA_W]};   // borrow out
      OP_MFHI: bus.aluOutE = hi;
      OP_MFLO: bus.aluOutE = lo;
      default: bus.aluOutE = '0;
    endcase
  end

`ifdef EX_OVF_DETECT_EN
  assign bus.ovfE = ((op == OP_ADD) || (op == OP_SUB)) && ovf_raw;
`else
  assign bus.ovfE = 1'b0;
`endif

  // ---------------- MDU control ----------------
  assign is_md_op   = (op[4:2] == 3'b100);   // MULT, MULTU, DIV, DIVU
  assign is_hilo_op = (op[4:2] == 3'b101);   // MFHI, MFLO, MTHI, MTLO

  // A squashed instruction never needs to stall, so flushE masks the request.
  assign bus.mdBusyE = !bus.flushE &&
                       ((is_md_op && (state != MD_DONE)) ||
                        (is_hilo_op && (state != MD_IDLE)));

  // Magnitudes and sign flags; op[0] == 0 selects the signed variants.
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;
  assign a_neg = !op[0] && a[DATA_W-1];
  assign b_neg = !op[0] && b[DATA_W-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  // Multiply step: {acc_hi,acc_lo} holds partial product over the remaining multiplier bits.
  logic [DATA_W:0]   mul_add;
  assign mul_add = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});

  // Divide step: acc_hi is the remainder, acc_lo shifts dividend out and quotient in.
  logic [DATA_W:0]   rem_s;
  logic              div_ge;
  assign rem_s  = {acc_hi, acc_lo[DATA_W-1]};
  assign div_ge = (rem_s >= {1'b0, opnd});

  // Final sign correction, applied in DONE.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  assign prod_fix = (sign_a ^ sign_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  // Divide by zero: quotient is all ones regardless of signs; remainder already equals |dividend|.
  assign quo_fix  = (opnd == '0)       ? '1 :
                    (sign_a ^ sign_b)  ? -acc_lo : acc_lo;
  assign rem_fix  = sign_a ? -acc_hi : acc_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (!bus.flushE) begin
            if (is_md_op) begin
              state  <= MD_RUN;
              cnt    <= CNT_W'(DATA_W - 1);
              is_div <= op[1];
              sign_a <= a_neg;
              sign_b <= b_neg;
              acc_hi <= '0;
              acc_lo <= op[1] ? abs_a : abs_b;
              opnd   <= op[1] ? abs_b : abs_a;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        MD_RUN: begin
          if (bus.flushE) begin
            state <= MD_IDLE;
          end else begin
            if (is_div) begin
              acc_hi <= div_ge ? DATA_W'(rem_s - {1'b0, opnd}) : rem_s[DATA_W-1:0];
              acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
            end else begin
              {acc_hi, acc_lo} <= {mul_add, acc_lo[DATA_W-1:1]};
            end
            if (cnt == '0) state <= MD_DONE;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        MD_DONE: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*DATA_W-1:DATA_W];
            lo <= prod_fix[DATA_W-1:0];
          end
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_md_stage.sv
// Self-checking bench for ex_md_stage: directed ALU/MDU cases plus randomized traffic
// compared with a plain-arithmetic reference (SV * / % on 64-bit values).
module tb_ex_md_stage;
  localparam int DW = 32;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b01010;
  localparam logic [4:0] OP_SLT  = 5'b01011;
  localparam logic [4:0] OP_SLTU = 5'b01100;
  localparam logic [4:0] OP_MULT = 5'b10000;
  localparam logic [4:0] OP_MULTU= 5'b10001;
  localparam logic [4:0] OP_DIV  = 5'b10010;
  localparam logic [4:0] OP_DIVU = 5'b10011;
  localparam logic [4:0] OP_MFHI = 5'b10100;
  localparam logic [4:0] OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_MTHI = 5'b10110;
  localparam logic [4:0] OP_MTLO = 5'b10111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] m_hi, m_lo;   // reference HI/LO
  logic [4:0]    alu_codes [0:11];
  logic [4:0]    md_codes  [0:3];

  ex_md_stage_if #(.DATA_W(DW), .REG_AW(5)) bus ();

  ex_md_stage #(.DATA_W(DW), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU: returns {ovf, result}.
  function automatic logic [DW:0] ref_alu(input logic [4:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] y;
    logic          ov;
    longint        s;
    y = '0; ov = 1'b0; s = 0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADD: begin
        y = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        y = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: y = {31'b0, a < b};
      OP_MFHI: y = m_hi;
      OP_MFLO: y = m_lo;
      default: y = '0;
    endcase
`ifndef EX_OVF_DETECT_EN
    ov = 1'b0;
`endif
    return {ov, y};
  endfunction

  // Reference MDU: returns {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic signed [63:0] sa, sb;
    logic signed [DW-1:0] q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p = '0;
    case (op)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0)                                   p = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == '1)        p = {32'h0, 32'h80000000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          p = {r, q};
        end
      end
      OP_DIVU: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else        p = {a % b, a / b};
      end
      default: p = {m_hi, m_lo};
    endcase
    return p;
  endfunction

  task automatic idle_inputs();
    bus.regData1D = '0; bus.regData2D = '0; bus.resultW = '0; bus.aluOutM = '0;
    bus.signExtImmE = '0; bus.rtE = '0; bus.rdE = '0; bus.forward1E = 2'b00;
    bus.forward2E = 2'b00; bus.aluCtrlE = OP_AND; bus.aluSrcE = 1'b0;
    bus.regDstE = 1'b0; bus.flushE = 1'b0;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.forward1E = 2'b00; bus.forward2E = 2'b00; bus.aluSrcE = 1'b0; bus.flushE = 1'b0;
    bus.regData1D = a; bus.regData2D = b; bus.aluCtrlE = op;
  endtask

  // Issue an MD op, count stall cycles, then read LO and HI back.
  task automatic run_md(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo, input string tag);
    int n;
    @(negedge clk);
    set_op(op, a, b);
    #1;
    n = 0;
    while (bus.mdBusyE === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(DW + 1));
    m_hi = exp_hi;
    m_lo = exp_lo;
    @(negedge clk);
    set_op(OP_MFLO, '0, '0);
    #1;
    check({tag, " busy_after"}, 64'(bus.mdBusyE), 64'd0);
    check({tag, " lo"}, 64'(bus.aluOutE), 64'(exp_lo));
    @(negedge clk);
    set_op(OP_MFHI, '0, '0);
    #1;
    check({tag, " hi"}, 64'(bus.aluOutE), 64'(exp_hi));
  endtask

  initial begin
    logic [DW:0]   r;
    logic [63:0]   md;
    logic [DW-1:0] a, b, exp_a, exp_rt, exp_b, v;
    logic [4:0]    op;

    alu_codes[0] = OP_AND;  alu_codes[1] = OP_OR;   alu_codes[2]  = OP_ADD;
    alu_codes[3] = OP_XOR;  alu_codes[4] = OP_SUB;  alu_codes[5]  = OP_SLT;
    alu_codes[6] = OP_SLTU; alu_codes[7] = 5'b00101; alu_codes[8] = OP_MFHI;
    alu_codes[9] = OP_MFLO; alu_codes[10] = 5'b11000; alu_codes[11] = 5'b11111;
    md_codes[0] = OP_MULT; md_codes[1] = OP_MULTU; md_codes[2] = OP_DIV; md_codes[3] = OP_DIVU;

    idle_inputs();
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check("rst busy", 64'(bus.mdBusyE), 64'd0);
    set_op(OP_MFHI, '0, '0); #1;
    check("rst hi", 64'(bus.aluOutE), 64'd0);
    set_op(OP_MFLO, '0, '0); #1;
    check("rst lo", 64'(bus.aluOutE), 64'd0);

    // ADD with M-stage forward on rs
    @(negedge clk);
    set_op(OP_ADD, 32'd99, 32'd7);
    bus.forward1E = 2'b10; bus.aluOutM = 32'd5; bus.rtE = 5'd9; bus.rdE = 5'd17; bus.regDstE = 1'b0;
    #1;
    check("fwd add out", 64'(bus.aluOutE), 64'd12);
    check("fwd add wreg", 64'(bus.writeRegE), 64'd9);
    bus.regDstE = 1'b1; #1;
    check("fwd add wreg rd", 64'(bus.writeRegE), 64'd17);

    // SLT / SLTU at the sign boundary
    set_op(OP_SLT, 32'h80000000, 32'd1); #1;
    check("slt", 64'(bus.aluOutE), 64'd1);
    set_op(OP_SLTU, 32'h80000000, 32'd1); #1;
    check("sltu", 64'(bus.aluOutE), 64'd0);

    // Signed overflow on ADD
    set_op(OP_ADD, 32'h7FFFFFFF, 32'd1); #1;
    check("ovf add out", 64'(bus.aluOutE), 64'h80000000);
`ifdef EX_OVF_DETECT_EN
    check("ovf add flag", 64'(bus.ovfE), 64'd1);
`else
    check("ovf add flag", 64'(bus.ovfE), 64'd0);
`endif

    // Directed MDU cases
    run_md(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3*7");
    run_md(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    run_md(OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, "divu 9/0");
    run_md(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div minneg/-1");

    // MTHI / MTLO, and a flushed MTLO that must not write
    @(negedge clk);
    set_op(OP_MTHI, 32'h12345678, '0); #1;
    check("mthi busy", 64'(bus.mdBusyE), 64'd0);
    m_hi = 32'h12345678;
    @(negedge clk);
    set_op(OP_MTLO, 32'hCAFEF00D, '0);
    m_lo = 32'hCAFEF00D;
    @(negedge clk);
    set_op(OP_MTLO, 32'hDEADBEEF, '0); bus.flushE = 1'b1;
    @(negedge clk);
    set_op(OP_MFHI, '0, '0); #1;
    check("mthi readback", 64'(bus.aluOutE), 64'(m_hi));
    set_op(OP_MFLO, '0, '0); #1;
    check("mtlo flushed", 64'(bus.aluOutE), 64'(m_lo));

    // Flush in RUN cycle 10 aborts MULTU; HI/LO keep prior values
    @(negedge clk);
    set_op(OP_MULTU, 32'd1000, 32'd3000);
    repeat (10) @(negedge clk);
    bus.flushE = 1'b1; #1;
    check("flush busy drop", 64'(bus.mdBusyE), 64'd0);
    @(negedge clk);
    set_op(OP_MFHI, '0, '0); #1;
    check("flush idle busy", 64'(bus.mdBusyE), 64'd0);
    check("flush hi kept", 64'(bus.aluOutE), 64'(m_hi));
    set_op(OP_MFLO, '0, '0); #1;
    check("flush lo kept", 64'(bus.aluOutE), 64'(m_lo));

    // Reset in the middle of a MULT
    @(negedge clk);
    set_op(OP_MULT, 32'h00012345, 32'h00067890);
    repeat (5) @(negedge clk);
    set_op(OP_MFHI, '0, '0);
    rst = 1'b1; #2; rst = 1'b0; #1;
    m_hi = '0; m_lo = '0;
    check("rst mid busy", 64'(bus.mdBusyE), 64'd0);
    check("rst mid hi", 64'(bus.aluOutE), 64'd0);
    set_op(OP_MFLO, '0, '0); #1;
    check("rst mid lo", 64'(bus.aluOutE), 64'd0);

    // Randomized MDU ops
    for (int i = 0; i < 8; i++) begin
      op = md_codes[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      if ($urandom_range(0, 5) == 0) b = '0;
      md = ref_md(op, a, b);
      run_md(op, a, b, md[63:32], md[31:0], $sformatf("rand md%0d op%b", i, op));
    end

    // Randomized ALU ops with random forwarding/immediate/destination
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      op = alu_codes[$urandom_range(0, 11)];
      bus.aluCtrlE = op;
      bus.flushE = 1'b0;
      bus.regData1D = $urandom; bus.regData2D = $urandom;
      bus.resultW = $urandom;   bus.aluOutM = $urandom;
      bus.signExtImmE = $urandom;
      bus.forward1E = 2'($urandom_range(0, 3));
      bus.forward2E = 2'($urandom_range(0, 3));
      bus.aluSrcE = 1'($urandom_range(0, 1));
      bus.regDstE = 1'($urandom_range(0, 1));
      bus.rtE = 5'($urandom_range(0, 31));
      bus.rdE = 5'($urandom_range(0, 31));
      exp_a  = (bus.forward1E == 2'b01) ? bus.resultW :
               (bus.forward1E == 2'b10) ? bus.aluOutM : bus.regData1D;
      exp_rt = (bus.forward2E == 2'b01) ? bus.resultW :
               (bus.forward2E == 2'b10) ? bus.aluOutM : bus.regData2D;
      exp_b  = bus.aluSrcE ? bus.signExtImmE : exp_rt;
      r = ref_alu(op, exp_a, exp_b);
      #1;
      check($sformatf("alu%0d out op%b", i, op), 64'(bus.aluOutE), 64'(r[DW-1:0]));
      check($sformatf("alu%0d ovf", i), 64'(bus.ovfE), 64'(r[DW]));
      check($sformatf("alu%0d wdata", i), 64'(bus.writeDataE), 64'(exp_rt));
      v = bus.regDstE ? 32'(bus.rdE) : 32'(bus.rtE);
      check($sformatf("alu%0d wreg", i), 64'(bus.writeRegE), 64'(v));
      check($sformatf("alu%0d busy", i), 64'(bus.mdBusyE), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
